icache_responder: RTL and testbench
===================================

# icache_responder

Instruction-side cache responder: the cache end of the datapath's instruction-fetch interface. Serves datapath fetch requests (`imemREN`/`imemaddr`) from a 16-frame, direct-mapped, one-word-per-frame array. On a miss it fills from the memory controller with a blocking request/wait handshake. Sits between the datapath and the memory arbiter, and also provides an invalidate input and hit/miss counters for performance debug.

## Interface
- `FRAMES`, 16: number of direct-mapped frames; power of two; index width `IW` = log2(`FRAMES`) = 4.
- `PC_INIT`, 0: reset value of the latched fill address.
- `CLK`  in  1  the single clock; all state updates on the rising edge.
- `nRST`  in  1  reset; synchronous, active-high (asserted = 1), sampled on the rising edge of `CLK`.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  fetch byte address; bits [1:0] are ignored.
- `ihit`  out  1  requested word is valid in `imemload` this cycle.
- `imemload`  out  32  fetched instruction word.
- `invalidate`  in  1  clears all valid bits.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory read address, word-aligned.
- `iwait`  in  1  memory busy; `iload` is valid in the cycle `iwait` = 0 while `iREN` = 1.
- `iload`  in  32  memory read data.
- `hit_count`  out  16  wrapping count of cycles with `ihit` = 1.
- `miss_count`  out  16  wrapping count of fills started.

## Operation
- Address split: tag = `imemaddr`[31:IW+2] (26 bits), index = `imemaddr`[IW+1:2], offset [1:0] ignored.
- Per frame: valid bit, 26-bit tag, 32-bit data.
- Lookup is combinational: match = valid[index] and tag[index] equals the request tag.
- `ihit` = `imemREN` and match and state IDLE and not `invalidate`.
- `imemload` = data[index] whenever `ihit` = 1, otherwise 0.
- State machine, two states:
  - IDLE:
    - If `imemREN` and not match and not `invalidate`: latch {tag, index} into the fill address, increment `miss_count`, go to FILL.
    - Otherwise stay in IDLE.
  - FILL:
    - `iREN` = 1 and `iaddr` = latched fill address with bits [1:0] = 0.
    - Both are held stable regardless of `imemREN`, `imemaddr` or `invalidate`.
    - When `iwait` = 0: write `iload` and the tag into the latched frame, set its valid bit (unless `invalidate` is high this cycle), and go to IDLE.
- In IDLE, `iREN` = 0 and `iaddr` = 0.
- A fill is never abandoned. If the datapath drops or changes its request mid-fill, the fill completes, and the new request is looked up afresh in IDLE.
- `invalidate` = 1 clears every valid bit at the edge, in either state. If it coincides with fill completion, the filled frame is left invalid.
- Counters wrap from 0xFFFF to 0x0000.

## Timing
- Reset (edge with `nRST` = 1):
  - Registers: state = IDLE, all valid = 0, fill address = `PC_INIT`, `hit_count` = 0, `miss_count` = 0.
  - Outputs after the edge: `iREN` = 0, `iaddr` = 0, `ihit` = 0, `imemload` = 0.
- Tag and data arrays are not reset.
- Reset mid-fill: `iREN` drops at the reset edge and the partial fill is discarded.
- Hit latency: 0 cycles. `ihit` is asserted combinationally in the same cycle as the request.
- Miss timing, with request seen in cycle 0:
  - Cycle 1: FILL, `iREN` = 1.
  - Cycle k: `iwait` = 0, so the frame is written at the end of cycle k.
  - Cycle k+1: IDLE, and `ihit` = 1 if the request is unchanged.
  - Minimum miss latency is 2 cycles (`iwait` = 0 in cycle 1).
- No bypass: `ihit` is never asserted while in FILL.
- Conflict misses: two addresses with the same index and different tag evict each other; each access after the first is a miss.

## Test plan
- Reset, then a request for 0x00000040. Required: `ihit` = 0; next cycle `iREN` = 1, `iaddr` = 0x00000040. Memory returns 0x8C220004 with `iwait` = 0 immediately. Required: `ihit` = 1 and `imemload` = 0x8C220004 two cycles after the request, and `miss_count` = 1.
- Re-request 0x00000042 after that fill. Required: same-cycle `ihit` = 1, data 0x8C220004, `hit_count` increments; no `iREN`.
- Conflict: fill 0x00000040, then request 0x00000440 (same index 0). Required: a miss with `iaddr` = 0x00000440; then 0x00000040 misses again, and `miss_count` = 3.
- Mid-fill request change: issue a miss with `iwait` = 1 for 5 cycles and change `imemaddr` during the fill. Required: `iaddr` stays at the original address for all 5 cycles, and the original frame becomes valid.
- `invalidate` asserted in the fill-completion cycle. Required: the next request to that address misses. Also, `invalidate` in IDLE forces `ihit` = 0 that cycle and all frames to miss afterwards.
- `nRST` = 1 during FILL. Required: `iREN` = 0 the next cycle, counters reset to 0, and a subsequent request misses.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache responder.
// The cache end takes the slave view; the datapath/memory environment takes the master view.
interface icache_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        invalidate;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, invalidate, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, invalidate, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking miss fill
// from the memory controller, a global invalidate and hit/miss counters.
module icache_responder #(
    parameter int          FRAMES  = 16,
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              nRST,
    icache_responder_if.slave bus
);
    localparam int IW = $clog2(FRAMES);
    localparam int TW = 32 - IW - 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [FRAMES-1:0] valid;
    logic [TW-1:0]     tag_mem  [FRAMES];
    logic [31:0]       data_mem [FRAMES];
    logic [31:2]       fill_word;
    logic [15:0]       hits;
    logic [15:0]       misses;

    logic [TW-1:0]     req_tag;
    logic [IW-1:0]     req_idx;
    logic [TW-1:0]     fill_tag;
    logic [IW-1:0]     fill_idx;
    logic              match;
    logic              hit;
    logic              miss_start;
    logic              fill_done;

    assign req_tag  = bus.imemaddr[31:IW+2];
    assign req_idx  = bus.imemaddr[IW+1:2];
    assign fill_tag = fill_word[31:IW+2];
    assign fill_idx = fill_word[IW+1:2];

    assign match      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit        = bus.imemREN && match && (state == IDLE) && !bus.invalidate;
    assign miss_start = bus.imemREN && !match && !bus.invalidate && (state == IDLE);
    assign fill_done  = (state == FILL) && !bus.iwait;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_start) state_next = FILL;
            FILL:    if (!bus.iwait) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state: FSM, valid bits, fill address and counters.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state     <= IDLE;
            valid     <= '0;
            fill_word <= PC_INIT[31:2];
            hits      <= 16'h0000;
            misses    <= 16'h0000;
        end else begin
            state <= state_next;
            if (hit)
                hits <= hits + 16'h0001;
            if (miss_start) begin
                fill_word <= {req_tag, req_idx};
                misses    <= misses + 16'h0001;
            end
            // Invalidate wins over a coincident fill so the new frame stays invalid.
            if (bus.invalidate)
                valid <= '0;
            else if (fill_done)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; a write during reset is dropped with the fill.
    always_ff @(posedge CLK) begin
        if (fill_done && !nRST) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.iload;
        end
    end

    assign bus.ihit       = hit;
    assign bus.imemload   = hit ? data_mem[req_idx] : 32'h0000_0000;
    assign bus.iREN       = (state == FILL);
    assign bus.iaddr      = (state == FILL) ? {fill_word, 2'b00} : 32'h0000_0000;
    assign bus.hit_count  = hits;
    assign bus.miss_count = misses;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: hits, misses, conflicts, mid-fill changes,
// invalidate and reset behaviour, each against hand-computed expectations.
module tb_icache_responder;
    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_errors;

    icache_responder_if bus();

    icache_responder #(
        .FRAMES  (16),
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nRST           = 1'b1;
        bus.imemREN    = 1'b0;
        bus.imemaddr   = 32'h0;
        bus.invalidate = 1'b0;
        bus.iwait      = 1'b1;
        bus.iload      = 32'h0;
        step();
        step();
        settle();
        check("rst_iREN",   {31'h0, bus.iREN}, 32'h0);
        check("rst_iaddr",  bus.iaddr, 32'h0);
        check("rst_ihit",   {31'h0, bus.ihit}, 32'h0);
        check("rst_load",   bus.imemload, 32'h0);
        check("rst_hits",   {16'h0, bus.hit_count}, 32'h0);
        check("rst_misses", {16'h0, bus.miss_count}, 32'h0);
        nRST = 1'b0;

        // Cold miss on 0x40, memory answers immediately
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0040;
        bus.iwait    = 1'b0;
        bus.iload    = 32'h8C22_0004;
        settle();
        check("t1_req_ihit", {31'h0, bus.ihit}, 32'h0);
        check("t1_req_iREN", {31'h0, bus.iREN}, 32'h0);
        step(); settle();
        check("t1_fill_iREN",  {31'h0, bus.iREN}, 32'h1);
        check("t1_fill_iaddr", bus.iaddr, 32'h0000_0040);
        check("t1_fill_ihit",  {31'h0, bus.ihit}, 32'h0);
        check("t1_misses",     {16'h0, bus.miss_count}, 32'h1);
        step(); settle();
        check("t1_done_ihit", {31'h0, bus.ihit}, 32'h1);
        check("t1_done_load", bus.imemload, 32'h8C22_0004);
        check("t1_done_iREN", {31'h0, bus.iREN}, 32'h0);

        // Re-request with a different byte offset: same-cycle hit
        step();
        bus.imemaddr = 32'h0000_0042;
        settle();
        check("t2_ihit",  {31'h0, bus.ihit}, 32'h1);
        check("t2_load",  bus.imemload, 32'h8C22_0004);
        check("t2_iREN",  {31'h0, bus.iREN}, 32'h0);
        check("t2_hits0", {16'h0, bus.hit_count}, 32'h1);
        step(); settle();
        check("t2_hits1", {16'h0, bus.hit_count}, 32'h2);

        // Conflict on index 0
        bus.imemaddr = 32'h0000_0440;
        bus.iload    = 32'h1111_1111;
        settle();
        check("t3_440_ihit", {31'h0, bus.ihit}, 32'h0);
        step(); settle();
        check("t3_440_iREN",  {31'h0, bus.iREN}, 32'h1);
        check("t3_440_iaddr", bus.iaddr, 32'h0000_0440);
        check("t3_440_miss",  {16'h0, bus.miss_count}, 32'h2);
        step(); settle();
        check("t3_440_hit",  {31'h0, bus.ihit}, 32'h1);
        check("t3_440_load", bus.imemload, 32'h1111_1111);
        bus.imemaddr = 32'h0000_0040;
        bus.iload    = 32'h8C22_0004;
        settle();
        check("t3_040_ihit", {31'h0, bus.ihit}, 32'h0);
        step(); settle();
        check("t3_040_iaddr", bus.iaddr, 32'h0000_0040);
        check("t3_040_miss",  {16'h0, bus.miss_count}, 32'h3);
        step(); settle();
        check("t3_040_hit",  {31'h0, bus.ihit}, 32'h1);
        check("t3_040_load", bus.imemload, 32'h8C22_0004);

        // Long fill while the datapath wanders
        bus.imemaddr = 32'h0000_0084;
        bus.iwait    = 1'b1;
        bus.iload    = 32'hA5A5_0084;
        settle();
        check("t4_req_ihit", {31'h0, bus.ihit}, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            bus.imemaddr = 32'h0000_0100 + 32'(i * 4);
            bus.imemREN  = (i % 2 == 0);
            settle();
            check("t4_wait_iaddr", bus.iaddr, 32'h0000_0084);
            check("t4_wait_iREN",  {31'h0, bus.iREN}, 32'h1);
            check("t4_wait_ihit",  {31'h0, bus.ihit}, 32'h0);
            step();
        end
        bus.iwait    = 1'b0;
        bus.imemaddr = 32'h0000_0200;
        settle();
        check("t4_last_iaddr", bus.iaddr, 32'h0000_0084);
        check("t4_last_iREN",  {31'h0, bus.iREN}, 32'h1);
        step();
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0084;
        settle();
        check("t4_hit",    {31'h0, bus.ihit}, 32'h1);
        check("t4_load",   bus.imemload, 32'hA5A5_0084);
        check("t4_misses", {16'h0, bus.miss_count}, 32'h4);

        // Invalidate coinciding with fill completion
        bus.imemaddr = 32'h0000_00C8;
        settle();
        check("t5_req_ihit", {31'h0, bus.ihit}, 32'h0);
        step();
        bus.invalidate = 1'b1;
        bus.iload      = 32'hDEAD_BEEF;
        settle();
        check("t5_fill_iREN",  {31'h0, bus.iREN}, 32'h1);
        check("t5_fill_iaddr", bus.iaddr, 32'h0000_00C8);
        step();
        bus.invalidate = 1'b0;
        bus.iload      = 32'hC8C8_C8C8;
        settle();
        check("t5_inv_ihit", {31'h0, bus.ihit}, 32'h0);
        check("t5_inv_iREN", {31'h0, bus.iREN}, 32'h0);
        step(); settle();
        check("t5_refill_miss", {16'h0, bus.miss_count}, 32'h6);
        step(); settle();
        check("t5_refill_hit",  {31'h0, bus.ihit}, 32'h1);
        check("t5_refill_load", bus.imemload, 32'hC8C8_C8C8);

        // Invalidate in IDLE
        bus.invalidate = 1'b1;
        settle();
        check("t5_idle_inv_ihit", {31'h0, bus.ihit}, 32'h0);
        check("t5_idle_inv_load", bus.imemload, 32'h0);
        step();
        bus.invalidate = 1'b0;
        bus.imemaddr   = 32'h0000_0040;
        settle();
        check("t5_after_040", {31'h0, bus.ihit}, 32'h0);
        bus.imemaddr = 32'h0000_0084;
        settle();
        check("t5_after_084", {31'h0, bus.ihit}, 32'h0);
        bus.imemaddr = 32'h0000_00C8;
        settle();
        check("t5_after_0C8", {31'h0, bus.ihit}, 32'h0);
        check("t5_after_iREN", {31'h0, bus.iREN}, 32'h0);

        // Reset in the middle of a fill
        bus.iwait = 1'b1;
        step(); settle();
        check("t6_fill_iREN", {31'h0, bus.iREN}, 32'h1);
        check("t6_fill_miss", {16'h0, bus.miss_count}, 32'h7);
        nRST = 1'b1;
        step();
        nRST = 1'b0;
        settle();
        check("t6_rst_iREN",   {31'h0, bus.iREN}, 32'h0);
        check("t6_rst_iaddr",  bus.iaddr, 32'h0);
        check("t6_rst_hits",   {16'h0, bus.hit_count}, 32'h0);
        check("t6_rst_misses", {16'h0, bus.miss_count}, 32'h0);
        check("t6_rst_ihit",   {31'h0, bus.ihit}, 32'h0);
        bus.imemaddr = 32'h0000_0040;
        settle();
        check("t6_040_ihit", {31'h0, bus.ihit}, 32'h0);
        step(); settle();
        check("t6_040_iREN",  {31'h0, bus.iREN}, 32'h1);
        check("t6_040_iaddr", bus.iaddr, 32'h0000_0040);
        check("t6_040_miss",  {16'h0, bus.miss_count}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
